mmio_bus_master: RTL and testbench
==================================

# mmio_bus_master

Bus initiator for the memory-mapped peripheral bus (4-bit byte write-enable, 32-bit address, write data, combinational read data) used by GPIO and the other I/O devices. It accepts commands over a valid/ready stream (single or burst, byte/half/word), issues the matching bus accesses with correct lane placement, and returns read data or write completion on a response stream. It sits between a debug/loader front end and the bridge, as a second master alongside the CPU.

## Interface
Parameters:
- None. Address and data are fixed at 32 bits; burst length field is 4 bits (1–16 beats).

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- sys_rstn  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high only in IDLE
- cmd_write  input  1  1 = write burst, 0 = read burst
- cmd_addr  input  32  start byte address
- cmd_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- cmd_len  input  4  beats minus 1
- wr_valid  input  1  write beat offered
- wr_ready  output  1  high only in WDATA
- wr_data  input  32  write beat, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  output  1  response held until accepted
- rsp_ready  input  1  response accepted
- rsp_data  output  32  read beat, zero-extended, right-aligned; 0 for write/error responses
- rsp_err  output  1  command rejected
- rsp_last  output  1  final response of the command
- bus_we  output  4  byte write enables; nonzero for exactly one cycle per write beat
- bus_addr  output  32  registered access address
- bus_wdata  output  32  lane-replicated write data
- bus_rdata  input  32  combinational read data for bus_addr

## Operation
- States: IDLE, WDATA, WSTB, RSTB, RESP.
- IDLE: cmd_ready=1. On cmd_valid: latch size, beats=cmd_len+1, bus_addr<=cmd_addr. Error check first: size==11, half with addr[0]=1, or word with addr[1:0]!=0 → RESP with rsp_err=1, rsp_last=1, rsp_data=0; no bus access. Else write → WDATA, read → RSTB.
- WDATA: wr_ready=1; on wr_valid register bus_wdata and bus_we, → WSTB.
- Lanes: byte: bus_wdata={4{d[7:0]}}, bus_we=4'b0001<<addr[1:0]. Half: {2{d[15:0]}}, 4'b0011<<{addr[1],1'b0}. Word: d, 4'b1111.
- WSTB: bus_we asserted this cycle only. Then bus_addr += 1/2/4 (by size, wraps mod 2^32), beats--; beats remaining → WDATA, else → RESP (rsp_data=0, err=0, last=1).
- RSTB: sample bus_rdata, extract lane (byte at addr[1:0], half at addr[1]), zero-extend into rsp_data, rsp_last=(beats==1), → RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready. On handshake: error or last → IDLE; read with beats remaining → bus_addr += step, beats--, → RSTB.
- Burst crossing or wrapping addresses is not checked; each beat is aligned because the start is aligned.

## Timing
- Reset (async, immediate): state IDLE, cmd_ready=1 after release, wr_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_last=0, bus_we=0, bus_addr=0, bus_wdata=0. Reset mid-burst abandons the command; bus_we drops in the same instant, no response issued.
- Read: cmd handshake at cycle t → bus_addr valid at t+1 (RSTB) → rsp_valid at t+2. rsp handshake at u → next bus_addr at u+1 → rsp_valid at u+2. Peak rate 1 beat / 2 cycles.
- Write: cmd at t → wr_ready from t+1. wr handshake at w → bus_we nonzero only during w+1 with bus_addr/bus_wdata valid → wr_ready again at w+2, or rsp_valid at w+2 after last beat.
- Error: cmd at t → rsp_valid (err=1) at t+1; bus_we stays 0.
- cmd_ready and wr_ready never high simultaneously; bus_we=0 in every state except WSTB.
- rsp_ready held high: RESP lasts exactly one cycle.

## Test plan
- Word write, addr 0x7F20, len 0, data 0x12345678 → one cycle bus_we=1111, bus_wdata=0x12345678, bus_addr=0x7F20; then rsp err=0 last=1.
- Byte write burst, addr 0x7F21, len 2, data 0xAA,0xBB,0xCC → bus_we 0010/0100/1000, addresses 0x7F21/22/23, wdata 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC.
- Half read, addr 0x7F02, bus_rdata=0xBEEF1234 → rsp_data=0x0000BEEF, last=1; rsp_ready held low 5 cycles → rsp stable, no new bus access.
- Word read burst len 3 from 0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; last only on 4th response.
- Misaligned word at 0x7F02 and size=11 → rsp_err=1, last=1, data=0, bus_we never asserted.
- Reset pulse between beats 2 and 3 of a 4-beat write → bus_we=0 immediately, all outputs at reset values, cmd_ready=1 after release, no response.

Source files
------------

// File: rtl/mmio_bus_master.sv
// Debug/loader bus initiator: turns single or burst commands (byte/half/word)
// into peripheral bus strobes and returns read data or write completion.
module mmio_bus_master (
    input  logic        clk_in,
    input  logic        sys_rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [3:0]  cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        rsp_last,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    // cmd, wr and rsp streams: a transfer happens on a rising edge where valid
    // and ready are both high; the source holds valid and payload until then.
    typedef enum logic [2:0] {IDLE, WDATA, WSTB, RSTB, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  size_q;
    logic [4:0]  beats_q;
    logic        cmd_bad;
    logic [31:0] step;
    logic [3:0]  we_lane;
    logic [31:0] wdata_lane;
    logic [31:0] rd_lane;

    always_comb begin
        cmd_bad = (cmd_size == 2'b11) ||
                  (cmd_size == 2'b01 && cmd_addr[0]) ||
                  (cmd_size == 2'b10 && cmd_addr[1:0] != 2'b00);
    end

    always_comb begin
        step       = 32'd4;
        we_lane    = 4'b1111;
        wdata_lane = wr_data;
        rd_lane    = bus_rdata;
        case (size_q)
            2'b00: begin
                step       = 32'd1;
                we_lane    = 4'b0001 << bus_addr[1:0];
                wdata_lane = {4{wr_data[7:0]}};
                case (bus_addr[1:0])
                    2'b00:   rd_lane = {24'd0, bus_rdata[7:0]};
                    2'b01:   rd_lane = {24'd0, bus_rdata[15:8]};
                    2'b10:   rd_lane = {24'd0, bus_rdata[23:16]};
                    default: rd_lane = {24'd0, bus_rdata[31:24]};
                endcase
            end
            2'b01: begin
                step       = 32'd2;
                we_lane    = 4'b0011 << {bus_addr[1], 1'b0};
                wdata_lane = {2{wr_data[15:0]}};
                rd_lane    = bus_addr[1] ? {16'd0, bus_rdata[31:16]} : {16'd0, bus_rdata[15:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cmd_valid) state_nxt = cmd_bad ? RESP : (cmd_write ? WDATA : RSTB);
            WDATA: if (wr_valid) state_nxt = WSTB;
            WSTB:  state_nxt = (beats_q > 5'd1) ? WDATA : RESP;
            RSTB:  state_nxt = RESP;
            RESP:  if (rsp_ready) state_nxt = (rsp_err || rsp_last) ? IDLE : RSTB;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        wr_ready  = (state == WDATA);
        rsp_valid = (state == RESP);
    end

    // bus_we is set only on the WDATA->WSTB edge, so it is nonzero for WSTB alone.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            size_q    <= 2'b00;
            beats_q   <= 5'd0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_we    <= 4'd0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
            rsp_last  <= 1'b0;
        end else begin
            bus_we <= 4'd0;
            case (state)
                IDLE: if (cmd_valid) begin
                    size_q   <= cmd_size;
                    beats_q  <= {1'b0, cmd_len} + 5'd1;
                    bus_addr <= cmd_addr;
                    rsp_data <= 32'd0;
                    rsp_err  <= cmd_bad;
                    rsp_last <= cmd_bad;
                end
                WDATA: if (wr_valid) begin
                    bus_wdata <= wdata_lane;
                    bus_we    <= we_lane;
                end
                WSTB: begin
                    bus_addr <= bus_addr + step;
                    beats_q  <= beats_q - 5'd1;
                    if (beats_q == 5'd1) begin
                        rsp_data <= 32'd0;
                        rsp_err  <= 1'b0;
                        rsp_last <= 1'b1;
                    end
                end
                RSTB: begin
                    rsp_data <= rd_lane;
                    rsp_err  <= 1'b0;
                    rsp_last <= (beats_q == 5'd1);
                end
                RESP: if (rsp_ready && !rsp_err && !rsp_last) begin
                    bus_addr <= bus_addr + step;
                    beats_q  <= beats_q - 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus_master.sv
// Bench for mmio_bus_master: directed cases then random commands, checked
// against a transaction-level model of lanes, addresses and response timing.
module tb_mmio_bus_master;

    logic        clk_in = 1'b0;
    logic        sys_rstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic [3:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_last;
    logic [31:0] rsp_data;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int          asserts = 0;
    int          fails = 0;
    logic [67:0] exp_q[$];
    logic [67:0] obs_q[$];
    logic        fix_en;
    logic [31:0] fix_val, salt;
    logic [31:0] wdat[16];

    mmio_bus_master dut (
        .clk_in(clk_in), .sys_rstn(sys_rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_last(rsp_last),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    // Clock / bus-side memory model
    always #5 clk_in = ~clk_in;

    assign bus_rdata = fix_en ? fix_val : ((bus_addr * 32'h9E3779B1) ^ salt);

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return fix_en ? fix_val : ((a * 32'h9E3779B1) ^ salt);
    endfunction

    function automatic logic [31:0] rd_expect(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] w;
        w = mem_word(a);
        if (sz == 2'b00) return (w >> (int'(a[1:0]) * 8)) & 32'h0000_00FF;
        if (sz == 2'b01) return (w >> (int'(a[1]) * 16)) & 32'h0000_FFFF;
        return w;
    endfunction

    function automatic logic [67:0] strobe_expect(input logic [31:0] a, input logic [1:0] sz,
                                                  input logic [31:0] d);
        logic [3:0]  we;
        logic [31:0] wd;
        if (sz == 2'b00) begin
            we = 4'd1 << int'(a[1:0]);
            wd = (d & 32'hFF) * 32'h0101_0101;
        end else if (sz == 2'b01) begin
            we = (a[1]) ? 4'b1100 : 4'b0011;
            wd = (d & 32'hFFFF) * 32'h0001_0001;
        end else begin
            we = 4'b1111;
            wd = d;
        end
        return {a, we, wd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        asserts++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: record every strobe cycle and check global invariants
    always @(negedge clk_in) begin
        if (sys_rstn) begin
            if (bus_we != 4'd0) begin
                obs_q.push_back({bus_addr, bus_we, bus_wdata});
                chk("we_only_in_strobe", {29'd0, cmd_ready, wr_ready, rsp_valid}, 32'd0);
            end
            chk("ready_exclusive", {31'd0, cmd_ready && wr_ready}, 32'd0);
        end
    end

    task automatic check_strobes();
        logic [67:0] o, e;
        chk("strobe_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            o = obs_q[i];
            e = exp_q[i];
            chk("strobe_addr", o[67:36], e[67:36]);
            chk("strobe_we", {28'd0, o[35:32]}, {28'd0, e[35:32]});
            chk("strobe_wdata", o[31:0], e[31:0]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Driver tasks
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [1:0] sz,
                            input logic [3:0] len);
        int n = 0;
        @(negedge clk_in);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_len = len;
        while (!cmd_ready && n < 40) begin @(negedge clk_in); n++; end
        chk("cmd_wait_bound", {31'd0, n < 40}, 32'd1);
        @(posedge clk_in); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_wr(input logic [31:0] d, input int dly, input int lat);
        int n = 0;
        @(negedge clk_in);
        repeat (dly) @(negedge clk_in);
        wr_valid = 1'b1; wr_data = d;
        while (!wr_ready && n < 40) begin @(negedge clk_in); n++; end
        chk("wr_ready_latency", n, (dly > 0) ? 0 : lat);
        @(posedge clk_in); #1;
        wr_valid = 1'b0;
    endtask

    task automatic get_rsp(input logic [31:0] ed, input logic ee, input logic el, input int lat,
                           input int hold, input logic do_addr, input logic [31:0] ea);
        int n = 0;
        logic [31:0] a0;
        @(negedge clk_in);
        while (!rsp_valid && n < 40) begin @(negedge clk_in); n++; end
        chk("rsp_latency", n, lat);
        if (!rsp_valid) return;
        a0 = bus_addr;
        repeat (hold) begin
            @(negedge clk_in);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_data", rsp_data, ed);
            chk("hold_addr", bus_addr, a0);
            chk("hold_we", {28'd0, bus_we}, 32'd0);
        end
        chk("rsp_data", rsp_data, ed);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
        chk("rsp_last", {31'd0, rsp_last}, {31'd0, el});
        if (do_addr) chk("bus_addr", bus_addr, ea);
        rsp_ready = 1'b1;
        @(posedge clk_in); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [1:0] sz,
                           input logic [3:0] len, input int hold);
        logic        bad;
        logic [31:0] addr, st;
        int          nb, dly;
        bad  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        st   = 32'd1 << sz;
        nb   = int'(len) + 1;
        addr = a;
        send_cmd(w, a, sz, len);
        if (bad) begin
            get_rsp(32'd0, 1'b1, 1'b1, 0, hold, 1'b1, a);
        end else if (w) begin
            for (int i = 0; i < nb; i++) begin
                exp_q.push_back(strobe_expect(addr, sz, wdat[i]));
                dly = $urandom_range(0, 2);
                send_wr(wdat[i], dly, (i == 0) ? 0 : 1);
                addr = addr + st;
            end
            get_rsp(32'd0, 1'b0, 1'b1, 1, hold, 1'b0, 32'd0);
        end else begin
            for (int i = 0; i < nb; i++) begin
                get_rsp(rd_expect(addr, sz), 1'b0, i == nb - 1, 1, hold, 1'b1, addr);
                addr = addr + st;
            end
        end
        check_strobes();
    endtask

    task automatic check_reset_outputs();
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
        chk("rst_bus_we", {28'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        sys_rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
        cmd_size = 2'b00; cmd_len = 4'd0; wr_valid = 1'b0; wr_data = 32'd0;
        rsp_ready = 1'b0; fix_en = 1'b0; fix_val = 32'd0; salt = $urandom;

        // Reset values
        repeat (2) @(negedge clk_in);
        check_reset_outputs();
        #3 sys_rstn = 1'b1;
        @(negedge clk_in);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Directed cases
        wdat[0] = 32'h1234_5678;
        run_cmd(1'b1, 32'h0000_7F20, 2'b10, 4'd0, 0);
        wdat[0] = 32'hAA; wdat[1] = 32'hBB; wdat[2] = 32'hCC;
        run_cmd(1'b1, 32'h0000_7F21, 2'b00, 4'd2, 1);
        fix_en = 1'b1; fix_val = 32'hBEEF_1234;
        run_cmd(1'b0, 32'h0000_7F02, 2'b01, 4'd0, 5);
        fix_en = 1'b0;
        run_cmd(1'b0, 32'hFFFF_FFF8, 2'b10, 4'd3, 0);
        run_cmd(1'b1, 32'h0000_7F02, 2'b10, 4'd0, 0);
        run_cmd(1'b0, 32'h0000_7F00, 2'b11, 4'd1, 2);
        run_cmd(1'b1, 32'h0000_7F01, 2'b01, 4'd3, 0);
        for (int i = 0; i < 16; i++) wdat[i] = $urandom;
        run_cmd(1'b1, 32'h0000_0100, 2'b00, 4'd15, 0);
        run_cmd(1'b0, 32'h0000_0200, 2'b01, 4'd15, 0);

        // Reset pulse in the middle of a 4-beat write
        wdat[0] = $urandom; wdat[1] = $urandom;
        exp_q.push_back(strobe_expect(32'h0000_7F40, 2'b10, wdat[0]));
        send_cmd(1'b1, 32'h0000_7F40, 2'b10, 4'd3);
        send_wr(wdat[0], 0, 0);
        send_wr(wdat[1], 0, 1);
        chk("midrst_we_before", {28'd0, bus_we}, 32'h0000_000F);
        sys_rstn = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk_in);
        #2 sys_rstn = 1'b1;
        repeat (4) begin
            @(negedge clk_in);
            chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
            chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        check_strobes();

        // Random commands, mostly legal
        for (int k = 0; k < 40; k++) begin
            a  = $urandom;
            sz = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            else sz = 2'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) wdat[i] = $urandom;
            salt = $urandom;
            run_cmd(1'($urandom_range(0, 1)), a, sz, 4'($urandom_range(0, 7)),
                    $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
